// File: rtl/vx_smem_requester.sv
// Shared-memory requester: issues warp loads/stores as per-lane requests and merges split read responses per tag.
// Requests issue combinationally and may be accepted over several cycles; a completing response shows cmp_valid next cycle, and responses stall while a completion is held.
module vx_smem_requester #(
    parameter int NUM_REQS   = 4,
    parameter int WORD_SIZE  = 4,
    parameter int ADDR_WIDTH = 30,
    parameter int NUM_TAGS   = 4,
    parameter int UTAG_WIDTH = 8,
    localparam int WORD_WIDTH = 8 * WORD_SIZE,
    localparam int TAG_BITS   = $clog2(NUM_TAGS)
) (
    input  logic                             clk,
    input  logic                             reset,

    input  logic                             req_valid,
    input  logic                             req_rw,
    input  logic [NUM_REQS-1:0]              req_tmask,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQS*WORD_SIZE-1:0]    req_byteen,
    input  logic [NUM_REQS*WORD_WIDTH-1:0]   req_data,
    input  logic [UTAG_WIDTH-1:0]            req_tag,
    output logic                             req_ready,

    output logic [NUM_REQS-1:0]              core_req_valid,
    output logic [NUM_REQS-1:0]              core_req_rw,
    output logic [NUM_REQS*ADDR_WIDTH-1:0]   core_req_addr,
    output logic [NUM_REQS*WORD_SIZE-1:0]    core_req_byteen,
    output logic [NUM_REQS*WORD_WIDTH-1:0]   core_req_data,
    output logic [NUM_REQS*TAG_BITS-1:0]     core_req_tag,
    input  logic [NUM_REQS-1:0]              core_req_ready,

    input  logic                             core_rsp_valid,
    input  logic [NUM_REQS-1:0]              core_rsp_tmask,
    input  logic [NUM_REQS*WORD_WIDTH-1:0]   core_rsp_data,
    input  logic [TAG_BITS-1:0]              core_rsp_tag,
    output logic                             core_rsp_ready,

    output logic                             cmp_valid,
    output logic [NUM_REQS-1:0]              cmp_tmask,
    output logic [NUM_REQS*WORD_WIDTH-1:0]   cmp_data,
    output logic [UTAG_WIDTH-1:0]            cmp_tag,
    input  logic                             cmp_ready,

    output logic                             busy
);

    logic [NUM_REQS-1:0]            sent_mask;
    logic                           issuing;
    logic [TAG_BITS-1:0]            alloc_r;

    logic [NUM_TAGS-1:0]            ent_valid;
    logic [NUM_REQS-1:0]            ent_pmask [NUM_TAGS];
    logic [NUM_REQS-1:0]            ent_tmask [NUM_TAGS];
    logic [UTAG_WIDTH-1:0]          ent_utag  [NUM_TAGS];
    logic [NUM_REQS*WORD_WIDTH-1:0] ent_data  [NUM_TAGS];

    logic                           free_avail;
    logic [TAG_BITS-1:0]            alloc_id;
    logic                           issue_ok;
    logic [NUM_REQS-1:0]            pend;
    logic [NUM_REQS-1:0]            fired;
    logic                           done;
    logic                           alloc_fire;
    logic [TAG_BITS-1:0]            cur_tag;

    logic                           rsp_fire;
    logic                           rsp_hit;
    logic [NUM_REQS-1:0]            rsp_upd;
    logic [NUM_REQS-1:0]            rsp_pmask;
    logic                           rsp_done;
    logic [NUM_REQS*WORD_WIDTH-1:0] rsp_merged;

    // Lowest-index free entry; allocation sees only the pre-update table.
    always_comb begin
        alloc_id = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                alloc_id = TAG_BITS'(i);
            end
        end
    end

    assign free_avail = ~(&ent_valid);
    assign issue_ok   = req_rw | issuing | free_avail;
    assign pend       = req_tmask & ~sent_mask;
    assign fired      = core_req_valid & core_req_ready;
    assign done       = req_valid & issue_ok & ((pend & ~fired) == '0);
    assign alloc_fire = req_valid & ~req_rw & ~issuing & free_avail & (|req_tmask);
    assign cur_tag    = issuing ? alloc_r : alloc_id;

    assign req_ready       = done;
    assign core_req_valid  = {NUM_REQS{req_valid & issue_ok}} & pend;
    assign core_req_rw     = {NUM_REQS{req_rw}};
    assign core_req_addr   = req_addr;
    assign core_req_byteen = req_byteen;
    assign core_req_data   = req_data;
    assign core_req_tag    = {NUM_REQS{cur_tag}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sent_mask <= '0;
            issuing   <= 1'b0;
            alloc_r   <= '0;
        end else begin
            if (done) begin
                sent_mask <= '0;
                issuing   <= 1'b0;
            end else begin
                if (|fired) begin
                    sent_mask <= sent_mask | fired;
                end
                if (alloc_fire) begin
                    issuing <= 1'b1;
                end
            end
            if (alloc_fire) begin
                alloc_r <= alloc_id;
            end
        end
    end

    assign core_rsp_ready = ~cmp_valid | cmp_ready;
    assign rsp_fire       = core_rsp_valid & core_rsp_ready;
    assign rsp_hit        = rsp_fire & ent_valid[core_rsp_tag];
    assign rsp_upd        = core_rsp_tmask & ent_pmask[core_rsp_tag];
    assign rsp_pmask      = ent_pmask[core_rsp_tag] & ~core_rsp_tmask;
    assign rsp_done       = rsp_hit & (rsp_pmask == '0);

    // Only lanes still pending take new data; stray lanes are dropped.
    always_comb begin
        rsp_merged = ent_data[core_rsp_tag];
        for (int l = 0; l < NUM_REQS; l++) begin
            if (rsp_upd[l]) begin
                rsp_merged[l*WORD_WIDTH +: WORD_WIDTH] = core_rsp_data[l*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                if (alloc_fire && (alloc_id == TAG_BITS'(i))) begin
                    ent_valid[i] <= 1'b1;
                end else if (rsp_done && (core_rsp_tag == TAG_BITS'(i))) begin
                    ent_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Allocation targets a free entry and responses a live one, so the writes never collide.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_pmask[alloc_id] <= req_tmask;
            ent_tmask[alloc_id] <= req_tmask;
            ent_utag[alloc_id]  <= req_tag;
            ent_data[alloc_id]  <= '0;
        end
        if (rsp_hit) begin
            ent_pmask[core_rsp_tag] <= rsp_pmask;
            ent_data[core_rsp_tag]  <= rsp_merged;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_valid <= 1'b0;
            cmp_tmask <= '0;
            cmp_data  <= '0;
            cmp_tag   <= '0;
        end else begin
            if (rsp_done) begin
                cmp_valid <= 1'b1;
                cmp_tmask <= ent_tmask[core_rsp_tag];
                cmp_data  <= rsp_merged;
                cmp_tag   <= ent_utag[core_rsp_tag];
            end else if (cmp_valid && cmp_ready) begin
                cmp_valid <= 1'b0;
            end
        end
    end

    assign busy = issuing | (|ent_valid) | cmp_valid;

    rsp_tag_live: assert property (@(posedge clk) disable iff (reset)
        rsp_fire |-> ent_valid[core_rsp_tag]);

endmodule

// File: tb/tb_vx_smem_requester.sv
// Randomized and directed bench for vx_smem_requester against a transaction-level table model.
module tb_vx_smem_requester;
    localparam int NR = 4;
    localparam int WS = 4;
    localparam int WW = 32;
    localparam int AW = 30;
    localparam int NT = 4;
    localparam int TB = 2;
    localparam int UW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_rw, req_ready;
    logic [NR-1:0]     req_tmask;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*WS-1:0]  req_byteen;
    logic [NR*WW-1:0]  req_data;
    logic [UW-1:0]     req_tag;
    logic [NR-1:0]     core_req_valid, core_req_rw, core_req_ready;
    logic [NR*AW-1:0]  core_req_addr;
    logic [NR*WS-1:0]  core_req_byteen;
    logic [NR*WW-1:0]  core_req_data;
    logic [NR*TB-1:0]  core_req_tag;
    logic              core_rsp_valid, core_rsp_ready;
    logic [NR-1:0]     core_rsp_tmask;
    logic [NR*WW-1:0]  core_rsp_data;
    logic [TB-1:0]     core_rsp_tag;
    logic              cmp_valid, cmp_ready, busy;
    logic [NR-1:0]     cmp_tmask;
    logic [NR*WW-1:0]  cmp_data;
    logic [UW-1:0]     cmp_tag;

    vx_smem_requester #(
        .NUM_REQS(NR), .WORD_SIZE(WS), .ADDR_WIDTH(AW), .NUM_TAGS(NT), .UTAG_WIDTH(UW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw), .req_tmask(req_tmask), .req_addr(req_addr),
        .req_byteen(req_byteen), .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
        .core_req_valid(core_req_valid), .core_req_rw(core_req_rw), .core_req_addr(core_req_addr),
        .core_req_byteen(core_req_byteen), .core_req_data(core_req_data), .core_req_tag(core_req_tag),
        .core_req_ready(core_req_ready),
        .core_rsp_valid(core_rsp_valid), .core_rsp_tmask(core_rsp_tmask), .core_rsp_data(core_rsp_data),
        .core_rsp_tag(core_rsp_tag), .core_rsp_ready(core_rsp_ready),
        .cmp_valid(cmp_valid), .cmp_tmask(cmp_tmask), .cmp_data(cmp_data), .cmp_tag(cmp_tag),
        .cmp_ready(cmp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid      = 1'b0;
        req_rw         = 1'b0;
        req_tmask      = '0;
        req_addr       = '0;
        req_byteen     = '0;
        req_data       = '0;
        req_tag        = '0;
        core_req_ready = '0;
        core_rsp_valid = 1'b0;
        core_rsp_tmask = '0;
        core_rsp_data  = '0;
        core_rsp_tag   = '0;
        cmp_ready      = 1'b0;
    endtask

    // Reference model: table of outstanding loads and queue of expected completions.
    typedef struct packed {
        logic [NR-1:0]    tm;
        logic [NR*WW-1:0] d;
        logic [UW-1:0]    ut;
    } cmp_t;

    logic             m_valid [NT];
    logic [NR-1:0]    m_pend  [NT];
    logic [NR-1:0]    m_tmask [NT];
    logic [UW-1:0]    m_utag  [NT];
    logic [NR*WW-1:0] m_data  [NT];
    cmp_t             exp_q[$];
    cmp_t             mon_x;
    bit               mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en && !reset && cmp_valid && cmp_ready) begin
            if (exp_q.size() == 0) begin
                check("cmp_unexpected", cmp_valid, 1'b0);
            end else begin
                mon_x = exp_q.pop_front();
                check("cmp_rand", {cmp_tmask, cmp_data, cmp_tag}, mon_x);
            end
        end
    end

    function automatic int model_nvalid();
        int n = 0;
        for (int i = 0; i < NT; i++) n += m_valid[i] ? 1 : 0;
        return n;
    endfunction

    task automatic do_load();
        logic [NR-1:0] tm, sent, rdy;
        logic [UW-1:0] ut;
        logic [1:0]    et;
        int            exp_tag;
        bit            done;
        tm = NR'($urandom_range(0, 15));
        ut = UW'($urandom);
        sent = '0;
        done = 1'b0;
        exp_tag = 0;
        for (int i = NT - 1; i >= 0; i--) if (!m_valid[i]) exp_tag = i;
        et = exp_tag[1:0];
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_tmask = tm;
        req_tag   = ut;
        for (int l = 0; l < NR; l++) req_addr[l*AW +: AW] = AW'($urandom);
        for (int c = 0; c < 20 && !done; c++) begin
            rdy = (c >= 10) ? 4'hF : NR'($urandom_range(0, 15));
            core_req_ready = rdy;
            cmp_ready = 1'($urandom_range(0, 1));
            #1;
            check("rl_valid", core_req_valid, tm & ~sent);
            if (tm != '0) check("rl_tag", core_req_tag, {NR{et}});
            done = ((tm & ~sent & ~rdy) == '0);
            check("rl_ready", req_ready, done);
            sent = sent | (tm & rdy);
            tick();
        end
        req_valid = 1'b0;
        core_req_ready = '0;
        if (tm != '0) begin
            m_valid[exp_tag] = 1'b1;
            m_pend[exp_tag]  = tm;
            m_tmask[exp_tag] = tm;
            m_utag[exp_tag]  = ut;
            m_data[exp_tag]  = '0;
        end
    endtask

    task automatic do_rsp();
        int            e;
        logic [NR-1:0] m;
        logic [NR*WW-1:0] d;
        bit            fired;
        e = $urandom_range(0, NT - 1);
        for (int k = 0; k < NT && !m_valid[e]; k++) e = (e + 1) % NT;
        m = NR'($urandom_range(1, 15));
        for (int l = 0; l < NR; l++) d[l*WW +: WW] = $urandom;
        core_rsp_valid = 1'b1;
        core_rsp_tag   = TB'(e);
        core_rsp_tmask = m;
        core_rsp_data  = d;
        fired = 1'b0;
        for (int c = 0; c < 20 && !fired; c++) begin
            cmp_ready = (c >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            fired = core_rsp_ready;
            tick();
        end
        core_rsp_valid = 1'b0;
        check("rsp_accept", fired, 1'b1);
        if (fired) begin
            for (int l = 0; l < NR; l++)
                if (m[l] && m_pend[e][l]) m_data[e][l*WW +: WW] = d[l*WW +: WW];
            m_pend[e] = m_pend[e] & ~m;
            if (m_pend[e] == '0) begin
                exp_q.push_back({m_tmask[e], m_data[e], m_utag[e]});
                m_valid[e] = 1'b0;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [NR*WW-1:0] d_a, d_b, d_m, d_1;
        d_1 = {32'd4, 32'd3, 32'd2, 32'd1};
        d_a = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        d_b = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
        d_m = {32'hE3, 32'hD2, 32'hE1, 32'hD0};
        for (int i = 0; i < NT; i++) m_valid[i] = 1'b0;

        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_cmp_valid", cmp_valid, 1'b0);
        check("rst_core_req_valid", core_req_valid, 4'h0);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_ready", core_rsp_ready, 1'b1);

        // Full load, single response batch.
        tick();
        req_valid = 1'b1; req_tmask = 4'hF; req_tag = 8'hA5; core_req_ready = 4'hF;
        for (int l = 0; l < NR; l++) req_addr[l*AW +: AW] = AW'(l * 16 + 3);
        #1;
        check("t1_valid", core_req_valid, 4'hF);
        check("t1_ready", req_ready, 1'b1);
        check("t1_tag", core_req_tag, 8'h00);
        check("t1_rw", core_req_rw, 4'h0);
        check("t1_addr", core_req_addr, {30'd51, 30'd35, 30'd19, 30'd3});
        tick(); idle(); #1;
        check("t1_busy", busy, 1'b1);
        core_rsp_valid = 1'b1; core_rsp_tag = 2'd0; core_rsp_tmask = 4'hF; core_rsp_data = d_1;
        #1;
        check("t1_rsp_ready", core_rsp_ready, 1'b1);
        tick(); idle(); #1;
        check("t1_cmp_valid", cmp_valid, 1'b1);
        check("t1_cmp_tmask", cmp_tmask, 4'hF);
        check("t1_cmp_data", cmp_data, d_1);
        check("t1_cmp_tag", cmp_tag, 8'hA5);
        check("t1_rsp_stall", core_rsp_ready, 1'b0);
        cmp_ready = 1'b1; #1;
        check("t1_rsp_ready_drain", core_rsp_ready, 1'b1);
        tick(); idle(); #1;
        check("t1_cmp_clear", cmp_valid, 1'b0);
        check("t1_idle", busy, 1'b0);

        // Store: no entry, never busy.
        req_valid = 1'b1; req_rw = 1'b1; req_tmask = 4'b0110; core_req_ready = 4'hF;
        req_data = {32'h1111, 32'h2222, 32'h3333, 32'h4444};
        #1;
        check("st_valid", core_req_valid, 4'b0110);
        check("st_rw", core_req_rw, 4'hF);
        check("st_ready", req_ready, 1'b1);
        check("st_data", core_req_data, {32'h1111, 32'h2222, 32'h3333, 32'h4444});
        check("st_busy_issue", busy, 1'b0);
        tick(); idle(); #1;
        check("st_busy_after", busy, 1'b0);

        // Partial acceptance over two cycles.
        req_valid = 1'b1; req_tmask = 4'hF; req_tag = 8'h22; core_req_ready = 4'b0011;
        #1;
        check("t2_valid0", core_req_valid, 4'hF);
        check("t2_ready0", req_ready, 1'b0);
        check("t2_tag0", core_req_tag, 8'h00);
        tick();
        core_req_ready = 4'b1100; #1;
        check("t2_valid1", core_req_valid, 4'b1100);
        check("t2_ready1", req_ready, 1'b1);
        check("t2_tag1", core_req_tag, 8'h00);
        check("t2_busy", busy, 1'b1);
        tick(); idle(); #1;
        check("t2_valid_off", core_req_valid, 4'h0);

        // Split response merges into one completion.
        req_valid = 1'b1; req_tmask = 4'hF; req_tag = 8'h33; core_req_ready = 4'hF;
        #1;
        check("t3_tag", core_req_tag, 8'h55);
        tick(); idle();
        core_rsp_valid = 1'b1; core_rsp_tag = 2'd1; core_rsp_tmask = 4'b0101; core_rsp_data = d_a;
        tick(); idle(); #1;
        check("t3_no_cmp", cmp_valid, 1'b0);
        core_rsp_valid = 1'b1; core_rsp_tag = 2'd1; core_rsp_tmask = 4'b1010; core_rsp_data = d_b;
        tick(); idle(); #1;
        check("t3_cmp_valid", cmp_valid, 1'b1);
        check("t3_cmp_data", cmp_data, d_m);
        check("t3_cmp_tag", cmp_tag, 8'h33);
        check("t3_cmp_tmask", cmp_tmask, 4'hF);
        cmp_ready = 1'b1;
        tick(); idle();
        core_rsp_valid = 1'b1; core_rsp_tag = 2'd0; core_rsp_tmask = 4'hF; core_rsp_data = d_1;
        tick(); idle(); #1;
        check("t3_cmp_tag_e0", cmp_tag, 8'h22);
        cmp_ready = 1'b1;
        tick(); idle();

        // Tag exhaustion and reuse of a freed entry.
        for (int i = 0; i < NT; i++) begin
            logic [1:0] t2b;
            t2b = i[1:0];
            req_valid = 1'b1; req_tmask = 4'hF; req_tag = UW'(8'h40 + i); core_req_ready = 4'hF;
            #1;
            check("t4_tag", core_req_tag, {NR{t2b}});
            tick();
        end
        idle();
        req_valid = 1'b1; req_tmask = 4'hF; req_tag = 8'h50; core_req_ready = 4'hF;
        #1;
        check("t4_full_valid", core_req_valid, 4'h0);
        check("t4_full_ready", req_ready, 1'b0);
        core_rsp_valid = 1'b1; core_rsp_tag = 2'd2; core_rsp_tmask = 4'hF; core_rsp_data = d_a;
        #1;
        check("t4_no_same_cycle_reuse", core_req_valid, 4'h0);
        tick();
        core_rsp_valid = 1'b0; #1;
        check("t4_reuse_valid", core_req_valid, 4'hF);
        check("t4_reuse_ready", req_ready, 1'b1);
        check("t4_reuse_tag", core_req_tag, 8'hAA);
        check("t4_cmp_tag", cmp_tag, 8'h42);
        check("t4_rsp_stall", core_rsp_ready, 1'b0);
        tick(); idle();
        cmp_ready = 1'b1;
        tick(); idle();
        for (int i = 0; i < NT; i++) begin
            logic [UW-1:0] eu;
            eu = (i == 2) ? 8'h50 : UW'(8'h40 + i);
            core_rsp_valid = 1'b1; core_rsp_tag = TB'(i); core_rsp_tmask = 4'hF; core_rsp_data = d_b;
            tick(); idle(); #1;
            check("t4_drain_tag", cmp_tag, eu);
            cmp_ready = 1'b1;
            tick(); idle();
        end
        #1;
        check("t4_idle", busy, 1'b0);

        // Randomized traffic against the model.
        mon_en = 1'b1;
        for (int it = 0; it < 80; it++) begin
            int nv;
            nv = model_nvalid();
            if (nv == NT || (nv > 0 && $urandom_range(0, 1) == 1)) do_rsp();
            else do_load();
        end
        for (int k = 0; k < 200 && model_nvalid() > 0; k++) do_rsp();
        cmp_ready = 1'b1;
        repeat (3) tick();
        mon_en = 1'b0;
        check("rand_leftover", 32'(exp_q.size()), 32'd0);
        check("rand_idle", busy, 1'b0);
        idle();

        // Reset with two entries pending and a partially issued load.
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1; req_tmask = 4'hF; req_tag = UW'(i); core_req_ready = 4'hF;
            tick();
        end
        req_tmask = 4'hF; core_req_ready = 4'b0001;
        tick();
        idle(); #1;
        check("rs_busy_before", busy, 1'b1);
        reset = 1'b1; #1;
        check("rs_busy", busy, 1'b0);
        check("rs_cmp_valid", cmp_valid, 1'b0);
        check("rs_core_req_valid", core_req_valid, 4'h0);
        check("rs_rsp_ready", core_rsp_ready, 1'b1);
        tick();
        reset = 1'b0;
        req_valid = 1'b1; req_tmask = 4'hF; core_req_ready = 4'h0;
        #1;
        check("rs_replay_valid", core_req_valid, 4'hF);
        check("rs_replay_tag", core_req_tag, 8'h00);
        tick(); idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
